// File: rtl/gui_icon_compositor.sv
// Icon compositor: maps screen pixels into a sprite ROM window, overlays the
// sprite on the background and renders the special-move cooldown state.
module gui_icon_compositor #(
    parameter int SCREEN_W        = 96,
    parameter int SCREEN_H        = 64,
    parameter int COOLDOWN_FRAMES = 180,
    parameter int FLASH_FRAMES    = 32,
    parameter int FLASH_HALF      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_begin,
    input  logic        pix_req,
    input  logic [12:0] pixel_index,
    input  logic [15:0] bg_colour,
    input  logic [6:0]  icon_dx,
    input  logic [5:0]  icon_dy,
    input  logic        special_trigger,
    output logic [12:0] rom_index,
    input  logic [15:0] rom_colour,
    output logic [15:0] oled_colour,
    output logic        out_valid,
    output logic        special_ready
);

    localparam int CNT_MAX   = (COOLDOWN_FRAMES > FLASH_FRAMES) ? COOLDOWN_FRAMES : FLASH_FRAMES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int BLINK_BIT = $clog2(FLASH_HALF);

    localparam logic [CNT_W-1:0] COOL_INIT  = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0] FLASH_INIT = CNT_W'(FLASH_FRAMES);

    typedef enum logic [1:0] {
        ST_READY    = 2'd0,
        ST_COOLDOWN = 2'd1,
        ST_FLASH    = 2'd2
    } state_t;

    state_t           state;
    state_t           mode_lat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_dec;
    logic             blink_vis;
    logic [6:0]       dx_lat;
    logic [5:0]       dy_lat;

    assign cnt_dec = cnt - CNT_W'(1);

    // mode_lat/blink_vis capture the state that holds for the coming frame,
    // so a trigger coinciding with frame_begin already renders as COOLDOWN.
    // NOTE: every register here uses <= so all of them see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_READY;
            mode_lat      <= ST_READY;
            cnt           <= '0;
            blink_vis     <= 1'b0;
            special_ready <= 1'b1;
            dx_lat        <= '0;
            dy_lat        <= '0;
        end else begin
            if (frame_begin) begin
                dx_lat <= icon_dx;
                dy_lat <= icon_dy;
            end
            case (state)
                ST_READY: begin
                    if (frame_begin)
                        mode_lat <= special_trigger ? ST_COOLDOWN : ST_READY;
                    if (special_trigger) begin
                        state         <= ST_COOLDOWN;
                        cnt           <= COOL_INIT;
                        special_ready <= 1'b0;
                    end
                end
                ST_COOLDOWN: begin
                    if (frame_begin) begin
                        if (cnt == CNT_W'(1)) begin
                            state     <= ST_FLASH;
                            cnt       <= FLASH_INIT;
                            mode_lat  <= ST_FLASH;
                            blink_vis <= FLASH_INIT[BLINK_BIT];
                        end else begin
                            cnt      <= cnt_dec;
                            mode_lat <= ST_COOLDOWN;
                        end
                    end
                end
                ST_FLASH: begin
                    if (frame_begin) begin
                        if (cnt == CNT_W'(1)) begin
                            state         <= ST_READY;
                            cnt           <= '0;
                            mode_lat      <= ST_READY;
                            special_ready <= 1'b1;
                        end else begin
                            cnt       <= cnt_dec;
                            mode_lat  <= ST_FLASH;
                            blink_vis <= cnt_dec[BLINK_BIT];
                        end
                    end
                end
                default: begin
                    state         <= ST_READY;
                    mode_lat      <= ST_READY;
                    cnt           <= '0;
                    special_ready <= 1'b1;
                end
            endcase
        end
    end

    // Stage 1: window translation. A pixel arriving with frame_begin uses
    // the offsets being latched in that same cycle.
    logic [6:0]  dx_eff;
    logic [5:0]  dy_eff;
    logic [12:0] px_x;
    logic [12:0] px_y;
    logic [13:0] lx;
    logic [13:0] ly;
    logic        in_win;
    logic [12:0] win_index;

    always_comb begin
        dx_eff    = frame_begin ? icon_dx : dx_lat;
        dy_eff    = frame_begin ? icon_dy : dy_lat;
        px_x      = pixel_index % 13'(SCREEN_W);
        px_y      = pixel_index / 13'(SCREEN_W);
        lx        = {1'b0, px_x} - {7'b0, dx_eff};
        ly        = {1'b0, px_y} - {8'b0, dy_eff};
        in_win    = !lx[13] && (lx < 14'(SCREEN_W)) && !ly[13] && (ly < 14'(SCREEN_H));
        win_index = ly[12:0] * 13'(SCREEN_W) + lx[12:0];
    end

    logic        s1_valid;
    logic        s1_in_win;
    logic [15:0] s1_bg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_in_win <= 1'b0;
            s1_bg     <= '0;
            rom_index <= '0;
        end else begin
            s1_valid <= pix_req;
            if (pix_req) begin
                s1_in_win <= in_win;
                s1_bg     <= bg_colour;
                rom_index <= in_win ? win_index : 13'd0;
            end
        end
    end

    // Stage 2: composite; COOLDOWN halves each RGB565 field.
    logic [15:0] fg;
    logic        draw;

    always_comb begin
        fg   = (mode_lat == ST_COOLDOWN)
             ? {1'b0, rom_colour[15:12], 1'b0, rom_colour[10:6], 1'b0, rom_colour[4:1]}
             : rom_colour;
        draw = s1_in_win && (rom_colour != 16'h0000)
            && !((mode_lat == ST_FLASH) && !blink_vis);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            oled_colour <= '0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid)
                oled_colour <= draw ? fg : s1_bg;
        end
    end

endmodule
